// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter.
// Picks one ready functional unit per cycle by round-robin and grants it
// combinationally. The winner's tag and result are captured into a broadcast
// register, which drives the CDB for exactly one cycle on the next cycle.
module cdb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int LOCK_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*LOCK_WIDTH-1:0]    req_index,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_result,
  output logic [NUM_REQ-1:0]               grnt,
  input  logic                             flush,
  input  logic                             cdb_stall,
  output logic                             cdb_valid,
  output logic [LOCK_WIDTH-1:0]            cdb_index,
  output logic [DATA_WIDTH-1:0]            cdb_result
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      r_ptr;
  logic                  r_cdb_valid;
  logic [LOCK_WIDTH-1:0] r_cdb_index;
  logic [DATA_WIDTH-1:0] r_cdb_result;

  logic                  w_found;
  logic [PTR_W-1:0]      w_win;
  logic [PTR_W:0]        w_sum;
  logic                  w_grant_en;
  logic [NUM_REQ-1:0]    w_grnt;
  logic [LOCK_WIDTH-1:0] w_tag;
  logic [DATA_WIDTH-1:0] w_data;
  logic [PTR_W-1:0]      w_ptr_nxt;

  // Round-robin search: scan rr_ptr..NUM_REQ-1 then 0..rr_ptr-1; first set bit wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_REQ))
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      if (!w_found && req_valid[w_sum[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[PTR_W-1:0];
      end
    end
  end

  // A grant is suppressed by stall, flush or reset; grant is one-hot on the winner.
  assign w_grant_en = w_found && !cdb_stall && !flush && rst;

  // One-hot grant vector for the winning unit (zero when no grant).
  always_comb begin
    w_grnt = '0;
    if (w_grant_en)
      w_grnt[w_win] = 1'b1;
  end

  // Mux the granted unit's tag and result; zero when nothing is granted.
  always_comb begin
    w_tag  = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grnt[i]) begin
        w_tag  = req_index[i*LOCK_WIDTH +: LOCK_WIDTH];
        w_data = req_result[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pointer advances past the winner with an explicit wrap compare, so
  // NUM_REQ need not be a power of two.
  assign w_ptr_nxt = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  // Broadcast register: single-cycle capture of the winner, cleared otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr        <= '0;
      r_cdb_valid  <= 1'b0;
      r_cdb_index  <= '0;
      r_cdb_result <= '0;
    end else if (w_grant_en) begin
      r_ptr        <= w_ptr_nxt;
      r_cdb_valid  <= 1'b1;
      r_cdb_index  <= w_tag;
      r_cdb_result <= w_data;
    end else begin
      r_cdb_valid  <= 1'b0;
      r_cdb_index  <= '0;
      r_cdb_result <= '0;
    end
  end

  assign grnt       = w_grnt;
  assign cdb_valid  = r_cdb_valid;
  assign cdb_index  = r_cdb_index;
  assign cdb_result = r_cdb_result;

endmodule
